// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one byte-wide memory port between instruction fetch and load/store.
// Latency from grant cycle T: reads respond at T+N+2, writes at T+N+1 (N = 4/2/1 byte beats).
// Backpressure: one transaction in flight; requests are only granted in IDLE and must be held until gnt.
module rv_mem_arbiter #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;        // 1 = data requester owns the transaction
    logic        last_gnt_q, last_gnt_d;  // 1 = data was granted last, 0 = fetch
    logic [31:0] base_q, base_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  last_q, last_d;          // index of the final beat (N-1)
    logic [1:0]  beat_q, beat_d;
    logic        cap_vld_q, cap_vld_d;    // a read byte arrives on mem_dout this cycle
    logic [1:0]  cap_idx_q, cap_idx_d;    // byte lane that byte belongs to
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        pick_d;
    logic        take_d;
    logic        take_if;
    logic [31:0] rbuf_mrg;
    logic [31:0] load_ext;
    logic        unused_if_addr;

    // Fetch addresses are word aligned; the low two bits carry no information.
    assign unused_if_addr = ^if_addr[1:0];

    // Data wins a tie when prioritised, otherwise the requester not served last wins.
    // Grants are masked while reset is asserted so every output is quiet during reset.
    assign pick_d  = d_req & (~if_req | DATA_PRIO | ~last_gnt_q);
    assign take_d  = (state_q == S_IDLE) & sysreset & pick_d;
    assign take_if = (state_q == S_IDLE) & sysreset & if_req & ~pick_d;

    assign busy     = (state_q != S_IDLE);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Merge the byte returning this cycle into the assembly buffer.
    always_comb begin
        rbuf_mrg = rbuf_q;
        if (cap_vld_q) begin
            rbuf_mrg[{cap_idx_q, 3'b000} +: 8] = mem_dout;
        end
    end

    // Sign or zero extend narrow loads; a word result passes through untouched.
    always_comb begin
        case (last_q)
            2'd0:    load_ext = {{24{rbuf_mrg[7] & ~uns_q}}, rbuf_mrg[7:0]};
            2'd1:    load_ext = {{16{rbuf_mrg[15] & ~uns_q}}, rbuf_mrg[15:0]};
            default: load_ext = rbuf_mrg;
        endcase
    end

    // Next-state, datapath and port outputs for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        base_d     = base_q;
        we_d       = we_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        beat_d     = beat_q;
        cap_vld_d  = 1'b0;
        cap_idx_d  = cap_idx_q;
        rbuf_d     = rbuf_mrg;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_din    = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (take_d) begin
                    d_gnt      = 1'b1;
                    owner_d    = 1'b1;
                    last_gnt_d = 1'b1;
                    base_d     = d_addr;
                    we_d       = d_we;
                    uns_d      = d_unsigned;
                    wdata_d    = d_wdata;
                    last_d     = d_size[1] ? 2'd3 : (d_size[0] ? 2'd1 : 2'd0);
                    beat_d     = 2'd0;
                    rbuf_d     = 32'd0;
                    state_d    = S_ISSUE;
                end else if (take_if) begin
                    if_gnt     = 1'b1;
                    owner_d    = 1'b0;
                    last_gnt_d = 1'b0;
                    base_d     = {if_addr[31:2], 2'b00};
                    we_d       = 1'b0;
                    uns_d      = 1'b0;
                    wdata_d    = 32'd0;
                    last_d     = 2'd3;
                    beat_d     = 2'd0;
                    rbuf_d     = 32'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_addr = base_q + {30'd0, beat_q};
                mem_din  = wdata_q[{beat_q, 3'b000} +: 8];
                if (!we_q) begin
                    cap_vld_d = 1'b1;
                    cap_idx_d = beat_q;
                end
                if (beat_q == last_q) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            S_WAIT: begin
                // The final byte lands now; publish the assembled result for RESP.
                if (owner_q) begin
                    d_rdata_d = load_ext;
                end else begin
                    if_rdata_d = rbuf_mrg;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q) begin
                    d_rvalid = 1'b1;
                end else begin
                    if_rvalid = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, beat counter and read-data assembly registers.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b0;
            base_q     <= 32'd0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= 32'd0;
            last_q     <= 2'd0;
            beat_q     <= 2'd0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= 2'd0;
            rbuf_q     <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            base_q     <= base_d;
            we_q       <= we_d;
            uns_q      <= uns_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            rbuf_q     <= rbuf_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed vector table, arbitration and reset sequences,
// then random single-requester transactions checked against a byte-array reference model.
module tb_rv_mem_arbiter;

    logic        sysclk;
    logic        sysreset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        busy;

    // Round-robin instance: only its arbitration order is examined.
    logic        rr_if_req;
    logic [31:0] rr_if_addr;
    logic        rr_if_gnt;
    logic        rr_if_rvalid;
    logic [31:0] rr_if_rdata;
    logic        rr_d_req;
    logic        rr_d_we;
    logic [1:0]  rr_d_size;
    logic        rr_d_unsigned;
    logic [31:0] rr_d_addr;
    logic [31:0] rr_d_wdata;
    logic        rr_d_gnt;
    logic        rr_d_rvalid;
    logic [31:0] rr_d_rdata;
    logic        rr_mem_en;
    logic        rr_mem_we;
    logic [31:0] rr_mem_addr;
    logic [7:0]  rr_mem_din;
    logic [7:0]  rr_mem_dout;
    logic        rr_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  init_mem [4096];
    logic [7:0]  ref_mem  [4096];
    logic [7:0]  tb_mem   [4096];
    bit          preload_done = 1'b0;
    logic [31:0] m_d;
    logic [31:0] m_if;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    rv_mem_arbiter #(.DATA_PRIO(1'b1)) u_dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    rv_mem_arbiter #(.DATA_PRIO(1'b0)) u_rr (
        .sysclk(sysclk), .sysreset(sysreset),
        .if_req(rr_if_req), .if_addr(rr_if_addr), .if_gnt(rr_if_gnt),
        .if_rvalid(rr_if_rvalid), .if_rdata(rr_if_rdata),
        .d_req(rr_d_req), .d_we(rr_d_we), .d_size(rr_d_size), .d_unsigned(rr_d_unsigned),
        .d_addr(rr_d_addr), .d_wdata(rr_d_wdata), .d_gnt(rr_d_gnt),
        .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata),
        .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_din(rr_mem_din), .mem_dout(rr_mem_dout), .busy(rr_busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Byte memory seen by the DUT: registered read, one cycle of latency.
    always @(posedge sysclk) begin
        if (!preload_done) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= init_mem[i];
            preload_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[11:0]] <= mem_din;
            else        mem_dout <= tb_mem[mem_addr[11:0]];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a transaction is N consecutive bytes, little-endian, with load extension.
    function automatic logic [31:0] model(input bit is_d, input bit we, input logic [1:0] size,
                                          input bit uns, input logic [31:0] addr,
                                          input logic [31:0] wdata);
        int          n;
        logic [31:0] a;
        logic [31:0] v;
        n = !is_d ? 4 : (size >= 2'd2 ? 4 : (size == 2'd1 ? 2 : 1));
        a = is_d ? addr : (addr & 32'hFFFF_FFFC);
        if (is_d && we) begin
            for (int i = 0; i < n; i++) ref_mem[12'(a + 32'(i))] = 8'(wdata >> (8 * i));
            return m_d;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + 32'(i))]) << (8 * i));
        if (is_d && !uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (is_d && !uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        if (is_d) m_d = v;
        else      m_if = v;
        return v;
    endfunction

    // Drive one requester and wait (bounded) for its grant; returns at the grant cycle.
    task automatic grant(input bit is_d, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        bit got;
        @(negedge sysclk);
        if (is_d) begin
            d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        #1;
        waited = 0;
        got = is_d ? d_gnt : if_gnt;
        while (!got && waited < 12) begin
            @(negedge sysclk); #1;
            waited++;
            got = is_d ? d_gnt : if_gnt;
        end
        chk32("gnt_wait", waited, 0);
        chk1("busy_at_gnt", busy, 1'b0);
        chk1("other_gnt", is_d ? if_gnt : d_gnt, 1'b0);
    endtask

    // Check cycles T+1..T+lat: byte beats, busy, no grants, single response with data.
    task automatic follow(input bit is_d, input bit we, input int n, input int lat,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
        bit en;
        for (int j = 1; j <= lat; j++) begin
            @(negedge sysclk);
            if (j == 1) begin
                if (is_d) d_req = 1'b0;
                else      if_req = 1'b0;
            end
            #1;
            en = (j <= n);
            chk1("busy", busy, 1'b1);
            chk1("no_gnt_busy", if_gnt | d_gnt, 1'b0);
            chk1("mem_en", mem_en, en);
            chk1("mem_we", mem_we, en ? we : 1'b0);
            if (en) chk32("mem_addr", mem_addr, addr + 32'(j) - 32'd1);
            if (en && we) chk32("mem_din", {24'd0, mem_din}, {24'd0, wdata[8 * (j - 1) +: 8]});
            chk1("if_rvalid", if_rvalid, !is_d && j == lat);
            chk1("d_rvalid", d_rvalid, is_d && j == lat);
            if (j == lat) begin
                if (is_d) chk32("d_rdata", d_rdata, exp);
                else      chk32("if_rdata", if_rdata, exp);
            end
        end
    endtask

    task automatic txn(input bit is_d, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                       input logic [31:0] exp);
        int n;
        n = !is_d ? 4 : (size[1] ? 4 : (size[0] ? 2 : 1));
        grant(is_d, we, size, uns, addr, wdata);
        follow(is_d, is_d && we, n, lat, is_d ? addr : (addr & 32'hFFFF_FFFC), wdata, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ev, ef;
        int          order[$];
        int          cyc;

        sysreset = 1'b0;
        if_req = 1'b1; if_addr = 32'd0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        rr_if_req = 1'b0; rr_if_addr = 32'h0000_0040;
        rr_d_req = 1'b0; rr_d_we = 1'b1; rr_d_size = 2'd0; rr_d_unsigned = 1'b0;
        rr_d_addr = 32'h0000_0080; rr_d_wdata = 32'h0000_0055; rr_mem_dout = 8'h00;
        m_d = 32'd0; m_if = 32'd0;

        for (int i = 0; i < 4096; i++) init_mem[i] = 8'($urandom);
        init_mem[12'h104] = 8'h93; init_mem[12'h105] = 8'h00;
        init_mem[12'h106] = 8'h70; init_mem[12'h107] = 8'h00;
        init_mem[12'h300] = 8'h80;
        init_mem[12'hFFE] = 8'h11; init_mem[12'hFFF] = 8'h22;
        init_mem[12'h000] = 8'h33; init_mem[12'h001] = 8'h44;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_mem[i];

        //          is_d  we    size  uns   addr           wdata          lat exp
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0106, 32'h0000_0000, 6, 32'h0070_0093};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0300, 32'h0000_0000, 3, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0300, 32'h0000_0000, 3, 32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h1234_BEEF, 3, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0000_0000, 4, 32'h0000_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0000_0000, 4, 32'hFFFF_BEEF};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'hA1B2_C3D4, 5, 32'hFFFF_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0000_0000, 6, 32'hA1B2_C3D4};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0402, 32'h0000_0000, 3, 32'hFFFF_FFB2};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0403, 32'h1234_567F, 2, 32'hFFFF_FFB2};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0400, 32'h0000_0000, 6, 32'h7FB2_C3D4};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 6, 32'h4433_2211};
        vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0401, 32'h0000_0000, 6, 32'h7FB2_C3D4};

        // Reset state, with both requests asserted to show grants stay quiet.
        repeat (3) @(negedge sysclk);
        #1;
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'd0);
        chk32("rst_d_rdata", d_rdata, 32'd0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge sysclk);
        if_req = 1'b0; d_req = 1'b0; sysreset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            void'(model(vecs[i].is_d, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata));
            txn(vecs[i].is_d, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                vecs[i].lat, vecs[i].exp);
        end

        // Tie with data priority: data first, fetch on the following IDLE cycle.
        ev = model(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0300, 32'd0);
        ef = model(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0);
        @(negedge sysclk);
        d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b1; d_addr = 32'h0000_0300;
        if_addr = 32'h0000_0104; if_req = 1'b1; d_req = 1'b1;
        #1;
        chk1("prio_d_gnt", d_gnt, 1'b1);
        chk1("prio_if_held", if_gnt, 1'b0);
        follow(1'b1, 1'b0, 1, 3, 32'h0000_0300, 32'd0, ev);
        @(negedge sysclk); #1;
        chk1("prio_if_gnt_next", if_gnt, 1'b1);
        chk1("prio_d_gnt_next", d_gnt, 1'b0);
        follow(1'b0, 1'b0, 4, 6, 32'h0000_0104, 32'd0, ef);

        // Round-robin tie with both requests held across three grants.
        @(negedge sysclk);
        rr_if_req = 1'b1; rr_d_req = 1'b1;
        #1;
        cyc = 0;
        while (order.size() < 3 && cyc < 60) begin
            if (rr_if_gnt || rr_d_gnt) begin
                chk1("rr_gnt_excl", rr_if_gnt & rr_d_gnt, 1'b0);
                order.push_back(rr_d_gnt ? 1 : 0);
            end
            @(negedge sysclk); #1;
            cyc++;
        end
        rr_if_req = 1'b0; rr_d_req = 1'b0;
        chk32("rr_grant_count", order.size(), 3);
        if (order.size() > 0) chk32("rr_order0_data", order[0], 1);
        if (order.size() > 1) chk32("rr_order1_fetch", order[1], 0);
        if (order.size() > 2) chk32("rr_order2_data", order[2], 1);
        repeat (12) @(negedge sysclk);

        // Reset in the middle of a word load.
        grant(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0);
        @(negedge sysclk); d_req = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        sysreset = 1'b0;
        #1;
        chk1("midrst_mem_en", mem_en, 1'b0);
        chk1("midrst_mem_we", mem_we, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_d_rvalid", d_rvalid, 1'b0);
        for (int k = 4; k <= 7; k++) begin
            @(negedge sysclk);
            if (k == 5) sysreset = 1'b1;
            #1;
            chk1("midrst_no_rvalid", d_rvalid, 1'b0);
            chk1("midrst_idle", busy, 1'b0);
        end
        m_d = 32'd0; m_if = 32'd0;
        chk32("midrst_d_rdata_cleared", d_rdata, 32'd0);
        ev = model(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0);
        txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 6, ev);

        // Random single-requester traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            bit          r_is_d, r_we, r_uns;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata, r_exp;
            int          n;
            r_is_d  = 1'($urandom % 2);
            r_we    = r_is_d ? 1'($urandom % 2) : 1'b0;
            r_size  = 2'($urandom % 4);
            r_uns   = 1'($urandom % 2);
            r_addr  = $urandom;
            r_wdata = $urandom;
            n = !r_is_d ? 4 : (r_size >= 2'd2 ? 4 : (r_size == 2'd1 ? 2 : 1));
            r_exp = model(r_is_d, r_we, r_size, r_uns, r_addr, r_wdata);
            txn(r_is_d, r_we, r_size, r_uns, r_addr, r_wdata, r_we ? n + 1 : n + 2, r_exp);
            repeat ($urandom_range(0, 2)) @(negedge sysclk);
        end
        @(negedge sysclk); #1;
        chk32("final_if_rdata", if_rdata, m_if);
        chk32("final_d_rdata", d_rdata, m_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
